display_multiplexado: RTL and testbench

//  Downstream stage of the 4-digit BCD converter: captures sinal/milhar/centena/dezena/unidade
//  and drives a 5-position multiplexed 7-segment display (sign + 4 digits).

---
 rtl/display_multiplexado_pkg.sv | 53 +++++
 rtl/display_multiplexado_decodificador_7seg.sv | 27 ++
 rtl/display_multiplexado.sv | 164 ++++++++++++++++
 tb/tb_display_multiplexado.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/display_multiplexado_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-high segment
// patterns, scan positions and the one-hot anode table.
package display_multiplexado_pkg;

    localparam logic [6:0] SEG_0       = 7'h3F;
    localparam logic [6:0] SEG_1       = 7'h06;
    localparam logic [6:0] SEG_2       = 7'h5B;
    localparam logic [6:0] SEG_3       = 7'h4F;
    localparam logic [6:0] SEG_4       = 7'h66;
    localparam logic [6:0] SEG_5       = 7'h6D;
    localparam logic [6:0] SEG_6       = 7'h7D;
    localparam logic [6:0] SEG_7       = 7'h07;
    localparam logic [6:0] SEG_8       = 7'h7F;
    localparam logic [6:0] SEG_9       = 7'h6F;
    localparam logic [6:0] SEG_E       = 7'h79;
    localparam logic [6:0] SEG_MENOS   = 7'h40;
    localparam logic [6:0] SEG_APAGADO = 7'h00;

    typedef enum logic [2:0] {
        POS_UNID  = 3'd0,
        POS_DEZ   = 3'd1,
        POS_CENT  = 3'd2,
        POS_MILH  = 3'd3,
        POS_SINAL = 3'd4
    } posicao_t;

    function automatic logic [4:0] anodo_onehot(input posicao_t pos);
        logic [4:0] sel;
        case (pos)
            POS_UNID:  sel = 5'b00001;
            POS_DEZ:   sel = 5'b00010;
            POS_CENT:  sel = 5'b00100;
            POS_MILH:  sel = 5'b01000;
            POS_SINAL: sel = 5'b10000;
            default:   sel = 5'b00000;
        endcase
        return sel;
    endfunction

    function automatic posicao_t proxima_posicao(input posicao_t pos);
        posicao_t prox;
        case (pos)
            POS_UNID:  prox = POS_DEZ;
            POS_DEZ:   prox = POS_CENT;
            POS_CENT:  prox = POS_MILH;
            POS_MILH:  prox = POS_SINAL;
            POS_SINAL: prox = POS_UNID;
            default:   prox = POS_UNID;
        endcase
        return prox;
    endfunction

endpackage

// File: rtl/display_multiplexado_decodificador_7seg.sv
// BCD nibble to active-high {g,f,e,d,c,b,a} pattern; non-BCD values show 'E'.
module decodificador_7seg
    import display_multiplexado_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] padrao
);

    // Pure lookup, polarity is handled by the caller
    always_comb begin
        padrao = SEG_E;
        case (bcd)
            4'd0:    padrao = SEG_0;
            4'd1:    padrao = SEG_1;
            4'd2:    padrao = SEG_2;
            4'd3:    padrao = SEG_3;
            4'd4:    padrao = SEG_4;
            4'd5:    padrao = SEG_5;
            4'd6:    padrao = SEG_6;
            4'd7:    padrao = SEG_7;
            4'd8:    padrao = SEG_8;
            4'd9:    padrao = SEG_9;
            default: padrao = SEG_E;
        endcase
    end

endmodule

// File: rtl/display_multiplexado.sv
// Sign + 4-digit multiplexed 7-segment driver with leading-zero blanking and
// registered, polarity-selectable outputs.
module display_multiplexado
    import display_multiplexado_pkg::*;
#(
    parameter int DIVISOR       = 50000,
    parameter bit ATIVO_BAIXO   = 1'b1,
    parameter bit SUPRIME_ZEROS = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       atualizar,
    input  logic       sinal,
    input  logic [3:0] milhar,
    input  logic [3:0] centena,
    input  logic [3:0] dezena,
    input  logic [3:0] unidade,
    output logic [6:0] segmentos,
    output logic [4:0] anodos,
    output logic       varredura_fim
);

    localparam int             PW            = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [PW-1:0]  PRESC_MAX     = PW'(DIVISOR - 1);
    localparam logic [6:0]     SEG_INATIVO   = ATIVO_BAIXO ? 7'h7F : 7'h00;
    localparam logic [4:0]     ANODO_INATIVO = ATIVO_BAIXO ? 5'h1F : 5'h00;

    logic          sinal_r;
    logic [3:0]    milhar_r;
    logic [3:0]    centena_r;
    logic [3:0]    dezena_r;
    logic [3:0]    unidade_r;
    logic [PW-1:0] prescaler_r;
    posicao_t      indice_r;
    logic          fim_pend_r;
    logic [6:0]    segmentos_r;
    logic [4:0]    anodos_r;
    logic          varredura_fim_r;

    logic          wrap_s;
    logic [3:0]    nibble_s;
    logic [6:0]    digito_s;
    logic [6:0]    padrao_s;
    logic          milhar_zero_s;
    logic          centena_zero_s;
    logic          dezena_zero_s;

    assign wrap_s         = (prescaler_r == PRESC_MAX);
    assign milhar_zero_s  = (milhar_r == 4'd0);
    assign centena_zero_s = (centena_r == 4'd0);
    assign dezena_zero_s  = (dezena_r == 4'd0);

    // Capture registers for the value being displayed
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sinal_r   <= 1'b0;
            milhar_r  <= 4'd0;
            centena_r <= 4'd0;
            dezena_r  <= 4'd0;
            unidade_r <= 4'd0;
        end else if (atualizar) begin
            sinal_r   <= sinal;
            milhar_r  <= milhar;
            centena_r <= centena;
            dezena_r  <= dezena;
            unidade_r <= unidade;
        end else begin
            sinal_r   <= sinal_r;
            milhar_r  <= milhar_r;
            centena_r <= centena_r;
            dezena_r  <= dezena_r;
            unidade_r <= unidade_r;
        end
    end

    // Refresh prescaler and scan position; fim_pend_r marks a 4->0 wrap
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler_r <= '0;
            indice_r    <= POS_UNID;
            fim_pend_r  <= 1'b0;
        end else if (wrap_s) begin
            prescaler_r <= '0;
            indice_r    <= proxima_posicao(indice_r);
            fim_pend_r  <= (indice_r == POS_SINAL);
        end else begin
            prescaler_r <= prescaler_r + PW'(1);
            indice_r    <= indice_r;
            fim_pend_r  <= 1'b0;
        end
    end

    // Route the nibble of the current position into the single decoder
    always_comb begin
        nibble_s = 4'd0;
        case (indice_r)
            POS_UNID: nibble_s = unidade_r;
            POS_DEZ:  nibble_s = dezena_r;
            POS_CENT: nibble_s = centena_r;
            POS_MILH: nibble_s = milhar_r;
            default:  nibble_s = 4'd0;
        endcase
    end

    decodificador_7seg u_decodificador (
        .bcd    (nibble_s),
        .padrao (digito_s)
    );

    // Leading-zero blanking chains from milhar downwards; unidade is never blanked
    always_comb begin
        padrao_s = SEG_APAGADO;
        case (indice_r)
            POS_UNID: padrao_s = digito_s;
            POS_DEZ: begin
                if (SUPRIME_ZEROS && milhar_zero_s && centena_zero_s && dezena_zero_s) begin
                    padrao_s = SEG_APAGADO;
                end else begin
                    padrao_s = digito_s;
                end
            end
            POS_CENT: begin
                if (SUPRIME_ZEROS && milhar_zero_s && centena_zero_s) begin
                    padrao_s = SEG_APAGADO;
                end else begin
                    padrao_s = digito_s;
                end
            end
            POS_MILH: begin
                if (SUPRIME_ZEROS && milhar_zero_s) begin
                    padrao_s = SEG_APAGADO;
                end else begin
                    padrao_s = digito_s;
                end
            end
            POS_SINAL: begin
                if (sinal_r) begin
                    padrao_s = SEG_MENOS;
                end else begin
                    padrao_s = SEG_APAGADO;
                end
            end
            default: padrao_s = SEG_APAGADO;
        endcase
    end

    // Output registers with polarity applied
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            segmentos_r     <= SEG_INATIVO;
            anodos_r        <= ANODO_INATIVO;
            varredura_fim_r <= 1'b0;
        end else begin
            segmentos_r     <= ATIVO_BAIXO ? ~padrao_s : padrao_s;
            anodos_r        <= ATIVO_BAIXO ? ~anodo_onehot(indice_r) : anodo_onehot(indice_r);
            varredura_fim_r <= fim_pend_r;
        end
    end

    assign segmentos     = segmentos_r;
    assign anodos        = anodos_r;
    assign varredura_fim = varredura_fim_r;

endmodule

// File: tb/tb_display_multiplexado.sv
// Directed self-checking bench for display_multiplexado (DIVISOR=4, active-low, zero blanking).
module tb_display_multiplexado;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       atualizar = 1'b0;
    logic       sinal = 1'b0;
    logic [3:0] milhar = 4'd0;
    logic [3:0] centena = 4'd0;
    logic [3:0] dezena = 4'd0;
    logic [3:0] unidade = 4'd0;
    logic [6:0] segmentos;
    logic [4:0] anodos;
    logic       varredura_fim;

    int testes = 0;
    int falhas = 0;
    int cyc = 0;

    localparam logic [6:0] P_0  = 7'b1000000;
    localparam logic [6:0] P_2  = 7'b0100100;
    localparam logic [6:0] P_4  = 7'b0011001;
    localparam logic [6:0] P_E  = 7'b0000110;
    localparam logic [6:0] P_MN = 7'b0111111;
    localparam logic [6:0] P_BL = 7'b1111111;
    localparam logic [4:0] A_UN = 5'b11110;
    localparam logic [4:0] A_DZ = 5'b11101;
    localparam logic [4:0] A_CT = 5'b11011;
    localparam logic [4:0] A_ML = 5'b10111;
    localparam logic [4:0] A_SN = 5'b01111;
    localparam logic [4:0] A_OF = 5'b11111;

    display_multiplexado #(
        .DIVISOR       (4),
        .ATIVO_BAIXO   (1'b1),
        .SUPRIME_ZEROS (1'b1)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .atualizar     (atualizar),
        .sinal         (sinal),
        .milhar        (milhar),
        .centena       (centena),
        .dezena        (dezena),
        .unidade       (unidade),
        .segmentos     (segmentos),
        .anodos        (anodos),
        .varredura_fim (varredura_fim)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc = cyc + 1;
    endtask

    task automatic ate(input int alvo);
        while (cyc < alvo) tick();
    endtask

    task automatic confere(input string tag, input logic [4:0] an, input logic [6:0] seg,
                           input logic fim);
        testes = testes + 1;
        assert (anodos === an) else begin
            falhas = falhas + 1;
            $error("FAIL %s anodos: observed %b expected %b", tag, anodos, an);
        end
        testes = testes + 1;
        assert (segmentos === seg) else begin
            falhas = falhas + 1;
            $error("FAIL %s segmentos: observed %b expected %b", tag, segmentos, seg);
        end
        testes = testes + 1;
        assert (varredura_fim === fim) else begin
            falhas = falhas + 1;
            $error("FAIL %s varredura_fim: observed %b expected %b", tag, varredura_fim, fim);
        end
    endtask

    task automatic carrega(input logic s, input logic [3:0] m, input logic [3:0] c,
                           input logic [3:0] d, input logic [3:0] u);
        atualizar = 1'b1;
        sinal     = s;
        milhar    = m;
        centena   = c;
        dezena    = d;
        unidade   = u;
    endtask

    initial begin
        // Reset must act before any clock edge
        #2 reset = 1'b1;
        #1 confere("reset_async", A_OF, P_BL, 1'b0);
        tick();
        tick();
        confere("reset_held", A_OF, P_BL, 1'b0);

        // Release and load -42 on the first edge
        reset = 1'b0;
        cyc = 0;
        carrega(1'b1, 4'd0, 4'd0, 4'd4, 4'd2);
        tick();
        atualizar = 1'b0;
        confere("n42_first_regs_zero", A_UN, P_0, 1'b0);
        ate(2);  confere("n42_unid", A_UN, P_2, 1'b0);
        ate(4);  confere("n42_unid_last", A_UN, P_2, 1'b0);
        ate(5);  confere("n42_dez", A_DZ, P_4, 1'b0);
        ate(9);  confere("n42_cent_blank", A_CT, P_BL, 1'b0);
        ate(13); confere("n42_milh_blank", A_ML, P_BL, 1'b0);
        ate(17); confere("n42_sinal", A_SN, P_MN, 1'b0);
        ate(20); confere("n42_sinal_last", A_SN, P_MN, 1'b0);
        ate(21); confere("n42_wrap_pulse", A_UN, P_2, 1'b1);
        ate(22); confere("n42_pulse_end", A_UN, P_2, 1'b0);
        ate(40); confere("n42_prewrap2", A_SN, P_MN, 1'b0);
        ate(41); confere("n42_wrap_pulse2", A_UN, P_2, 1'b1);

        // Zero: only units lit
        carrega(1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
        tick();
        atualizar = 1'b0;
        ate(43); confere("z_unid", A_UN, P_0, 1'b0);
        ate(45); confere("z_dez_blank", A_DZ, P_BL, 1'b0);
        ate(49); confere("z_cent_blank", A_CT, P_BL, 1'b0);
        ate(53); confere("z_milh_blank", A_ML, P_BL, 1'b0);
        ate(57); confere("z_sinal_blank", A_SN, P_BL, 1'b0);
        ate(61); confere("z_wrap_pulse", A_UN, P_0, 1'b1);

        // Non-BCD thousands: 'E' and no suppression below it
        carrega(1'b0, 4'hA, 4'd0, 4'd0, 4'd0);
        tick();
        atualizar = 1'b0;
        ate(63); confere("e_unid", A_UN, P_0, 1'b0);
        ate(65); confere("e_dez", A_DZ, P_0, 1'b0);
        ate(69); confere("e_cent", A_CT, P_0, 1'b0);
        ate(73); confere("e_milh", A_ML, P_E, 1'b0);
        ate(77); confere("e_sinal", A_SN, P_BL, 1'b0);

        // Load 42 exactly on the wrap edge into dezena (edge 84)
        ate(83);
        carrega(1'b0, 4'd0, 4'd0, 4'd4, 4'd2);
        tick();
        atualizar = 1'b0;
        confere("sim_old_unid", A_UN, P_0, 1'b0);
        ate(85); confere("sim_new_dez", A_DZ, P_4, 1'b0);
        ate(89); confere("sim_new_cent_blank", A_CT, P_BL, 1'b0);

        // Reset in the middle of the cent slot
        ate(90);
        reset = 1'b1;
        #1 confere("mid_reset_async", A_OF, P_BL, 1'b0);
        tick();
        tick();
        confere("mid_reset_held", A_OF, P_BL, 1'b0);
        reset = 1'b0;
        cyc = 0;
        tick();
        confere("rst_restart_unid", A_UN, P_0, 1'b0);
        ate(5);  confere("rst_restart_dez_blank", A_DZ, P_BL, 1'b0);
        ate(17); confere("rst_restart_sinal_blank", A_SN, P_BL, 1'b0);
        ate(21); confere("rst_restart_wrap", A_UN, P_0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
